// File: rtl/sb_master_gen.sv
// SB bus master issuing one INCR burst (1..MAX_BURST beats) per command from a single FSM.
// Define SB_MASTER_TIMEOUT_EN to abort after TIMEOUT_CYC cycles waiting for grant.
module sb_master_gen #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned TIMEOUT_CYC = 256,
  localparam int unsigned LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic              sb_clk,
  input  logic              sb_resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_lock,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              done_err,
  input  logic              sb_grant,
  input  logic              sb_ready,
  input  logic [1:0]        sb_resp,
  input  logic [DATA_W-1:0] sb_rdata,
  output logic              sb_busreq,
  output logic              sb_lock,
  output logic [1:0]        sb_trans,
  output logic [ADDR_W-1:0] sb_addr,
  output logic              sb_write,
  output logic [2:0]        sb_size,
  output logic [2:0]        sb_burst,
  output logic [DATA_W-1:0] sb_wdata
);

  // state      | meaning
  // IDLE       | waiting for a command
  // CHECK      | validate latched length and size
  // REQ        | bus requested, waiting for grant
  // ADDR       | address phase of the current beat
  // DATA       | data phase, waiting for the slave response
  // SPLIT_WAIT | split by slave, waiting for grant to resume
  // FIN        | release bus, pulse done
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_ADDR, S_DATA, S_SPLIT_WAIT, S_FIN
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [1:0] RESP_OKAY  = 2'd1;
  localparam logic [1:0] RESP_ERROR = 2'd2;
  localparam logic [1:0] RESP_SPLIT = 2'd3;
  localparam logic [2:0] BURST_INCR = 3'd1;
  localparam logic [2:0]        SIZE_LIM = 3'($clog2(DATA_W / 8));
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                write_q, write_d;
  logic                lock_q, lock_d;
  logic                err_q, err_d;
  logic                nonseq_q, nonseq_d;
  logic                held_q, held_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                ready_en_q;
  logic                tmo_hit;

  assign sb_addr  = addr_q;
  assign sb_size  = size_q;
  assign sb_write = write_q;
  assign sb_wdata = wdata_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;

`ifdef SB_MASTER_TIMEOUT_EN
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             waiting;

  assign waiting = (state_q == S_REQ) || (state_q == S_SPLIT_WAIT);
  assign tmo_hit = waiting && (tmo_q == '0);

  always_ff @(posedge sb_clk or negedge sb_resetn) begin
    if (!sb_resetn)                    tmo_q <= '0;
    else if (waiting && tmo_q != '0)   tmo_q <= tmo_q - 1'b1;
    else                               tmo_q <= TMO_LOAD;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    len_d      = len_q;
    beat_d     = beat_q;
    write_d    = write_q;
    lock_d     = lock_q;
    err_d      = err_q;
    nonseq_d   = nonseq_q;
    held_d     = held_q;
    wdata_d    = wdata_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_data_d  = rd_data_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    sb_busreq  = 1'b0;
    sb_lock    = 1'b0;
    sb_trans   = TR_IDLE;
    sb_burst   = 3'd0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = ready_en_q;
        if (cmd_valid && ready_en_q) begin
          addr_d   = cmd_addr;
          size_d   = cmd_size;
          len_d    = cmd_len;
          write_d  = cmd_write;
          lock_d   = cmd_lock;
          beat_d   = '0;
          err_d    = 1'b0;
          nonseq_d = 1'b1;
          held_d   = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (len_q == '0 || len_q > LEN_MAX || size_q > SIZE_LIM) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        sb_busreq = 1'b1;
        sb_lock   = lock_q;
        if (sb_grant) begin
          state_d = S_ADDR;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_ADDR: begin
        sb_busreq = 1'b1;
        sb_lock   = lock_q;
        if (!sb_grant) begin
          nonseq_d = 1'b1;
          state_d  = S_REQ;
        end else if (write_q && !held_q && !wr_valid) begin
          // stall for write data: BUSY only makes sense inside a started burst
          sb_trans = nonseq_q ? TR_IDLE : TR_BUSY;
          sb_burst = nonseq_q ? 3'd0 : BURST_INCR;
        end else begin
          sb_trans = nonseq_q ? TR_NONSEQ : TR_SEQ;
          sb_burst = BURST_INCR;
          nonseq_d = 1'b0;
          if (write_q && !held_q) begin
            wr_ready = 1'b1;
            wdata_d  = wr_data;
            held_d   = 1'b1;
          end
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        sb_busreq = 1'b1;
        sb_lock   = lock_q;
        if (sb_resp == RESP_SPLIT) begin
          nonseq_d = 1'b1;
          state_d  = S_SPLIT_WAIT;
        end else if (sb_ready && sb_resp == RESP_ERROR) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (sb_ready && sb_resp == RESP_OKAY) begin
          held_d = 1'b0;
          beat_d = beat_q + LEN_ONE;
          addr_d = addr_q + (ADDR_ONE << size_q);
          if (!write_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = sb_rdata;
          end
          if (beat_q + LEN_ONE == len_q) begin
            rd_last_d = !write_q;
            state_d   = S_FIN;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_SPLIT_WAIT: begin
        sb_busreq = 1'b1;
        sb_lock   = lock_q;
        if (sb_grant && sb_ready) begin
          state_d = S_ADDR;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done     = 1'b1;
        done_err = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cmd_ready stays low until the first clock after reset release
  always_ff @(posedge sb_clk or negedge sb_resetn) begin
    if (!sb_resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      write_q    <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      nonseq_q   <= 1'b0;
      held_q     <= 1'b0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      write_q    <= write_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      nonseq_q   <= nonseq_d;
      held_q     <= held_d;
      wdata_q    <= wdata_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: doc/sb_master_gen.md
Name: sb_master_gen

Overview:
- Parametrised, single-FSM SB bus master. Replaces the fixed 32-bit, separate read/write-FSM masters.
- A user-side command interface issues one INCR burst of 1..MAX_BURST beats, read or write.
- Streams write data in and read data out with valid/ready handshakes.
- Handles grant loss, SPLIT resume, ERROR abort and wait states. Sits between a test/DMA client and the SB arbiter/decoder.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; power of two, 8..1024
MAX_BURST, 8, maximum beats per command
TIMEOUT_CYC, 256, grant-wait limit in cycles (optional feature only)

Ports:
sb_clk  in  1  clock
sb_resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_lock  in  1  request locked burst
cmd_addr  in  ADDR_W  start address
cmd_size  in  3  beat size, log2 bytes
cmd_len  in  clog2(MAX_BURST+1)  beat count
wr_valid  in  1  write beat available
wr_data  in  DATA_W  write beat
wr_ready  out  1  write beat consumed
rd_valid  out  1  read beat valid, single-cycle pulse, no backpressure
rd_data  out  DATA_W  read beat
rd_last  out  1  final beat of burst
done  out  1  one-cycle completion pulse
done_err  out  1  valid with done; 1=aborted
sb_grant  in  1  arbiter grant
sb_ready  in  1  slave ready
sb_resp  in  2  0 none/wait, 1 OKAY, 2 ERROR, 3 SPLIT
sb_rdata  in  DATA_W  read data
sb_busreq  out  1  bus request
sb_lock  out  1  locked transfer
sb_trans  out  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
sb_addr  out  ADDR_W  address
sb_write  out  1  direction
sb_size  out  3  size
sb_burst  out  3  1=INCR, 0 when idle
sb_wdata  out  DATA_W  write data

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, counters 0. Reset mid-burst drops sb_busreq/sb_trans immediately; no done is produced.
- States: IDLE, CHECK, REQ, ADDR, DATA, SPLIT_WAIT, FIN.
- IDLE: cmd_ready=1. On accept, latch addr/size/len/write/lock and go to CHECK.
- CHECK (1 cycle): if cmd_len==0, cmd_len>MAX_BURST, or cmd_size>log2(DATA_W/8), go to FIN with err=1; the bus is never requested. Otherwise go to REQ.
- REQ: sb_busreq=1, sb_lock=latched lock. On sb_grant go to ADDR.
- ADDR (1 cycle per beat):
  - Grant low: sb_trans=IDLE, return to REQ.
  - Write with wr_valid=0: sb_trans=BUSY (SEQ bursts) or IDLE (first beat); stay in ADDR.
  - Otherwise drive sb_trans=NONSEQ for the first or resumed beat, SEQ for the rest, plus addr/size/write, and sb_burst=INCR.
  - On a write, also capture wr_data into sb_wdata with a wr_ready pulse. Go to DATA.
- DATA: sb_trans=IDLE.
  - resp SPLIT: go to SPLIT_WAIT, whatever sb_ready is.
  - sb_ready=1 & resp ERROR: go to FIN, err=1.
  - sb_ready=1 & resp OKAY: beat done. On a read, rd_valid=1 next cycle with registered sb_rdata. beat_cnt+1; addr += 1<<size, wrapping at 2^ADDR_W. If beat_cnt==len-1, set rd_last, go to FIN; else go to ADDR.
  - Anything else: wait in DATA.
- SPLIT_WAIT: sb_trans=IDLE, sb_busreq held. Leave on sb_grant&sb_ready, going to ADDR and re-issuing the split beat as NONSEQ at the same address. Write data is retained in sb_wdata, so no new wr_ready.
- FIN: sb_busreq=0, sb_lock=0, sb_burst=0. Pulse done (done_err=err), then IDLE.
- Latency: at least 2 cycles per beat. Grant-to-first-NONSEQ is 1 cycle.

Optional Feature:
- Macro SB_MASTER_TIMEOUT_EN.
- Defined: a counter runs in REQ and SPLIT_WAIT and clears on leaving them. At TIMEOUT_CYC cycles without grant, go to FIN with err=1; read beats already delivered stand.
- Undefined: no counter; wait indefinitely.

Test Plan:
- Write, addr 0x100, size 2, len 4, grant immediate, slave always OKAY -> NONSEQ@0x100 then SEQ@0x104/0x108/0x10C; four wr_ready; done=1, done_err=0.
- Read, len 3, sb_ready low 2 cycles on beat 1 -> rd_data matches each sb_rdata; rd_last with beat 3 only.
- Write, SPLIT on beat 2 of 4, grant returns after 5 cycles -> NONSEQ re-issued at beat-2 address with the same wdata; total four OKAY; done_err=0.
- Read, ERROR on beat 1 -> FIN; busreq drops; done_err=1; no further transfers.
- cmd_len=0 and cmd_size=7 (DATA_W=32) -> sb_busreq never asserted; done_err=1 within 3 cycles.
- With SB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=16, grant held low -> done_err=1 after 16 cycles in REQ. Without the macro, the block is still in REQ at cycle 100.
